// File: rtl/spi_ram_master_if.sv
// Host-side command/read-back bus of the SPI RAM initiator, plus its FSM state for observation.
interface spi_ram_master_if;
  // A command transfers on a rising sclk edge where cmd_valid && cmd_ready; the host keeps
  // cmd_op/cmd_data stable while cmd_valid waits; rd_valid is a one-cycle pulse with no back-pressure.
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic [2:0] state_dbg;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, rd_valid, rd_data, state_dbg
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, rd_valid, rd_data, state_dbg
  );
endinterface

// File: rtl/spi_ram_master.sv
// Mode-0 SPI initiator for the RAM-backed slave: sends 11-bit command frames and,
// for read-data commands, clocks back one byte after a configurable turnaround.
module spi_ram_master #(
  parameter int CLK_DIV  = 2,
  parameter int TURN_CYC = 2
) (
  input  logic             sclk,
  input  logic             rst,
  spi_ram_master_if.slave  host,
  output logic             spi_sck,
  output logic             ss_n,
  output logic             mosi,
  input  logic             miso
);

  typedef enum logic [2:0] {IDLE, CMD, TURN, RD, GAP} state_t;

  localparam int HW = $clog2(2 * CLK_DIV);
  localparam int BW = $clog2(((TURN_CYC > 11) ? TURN_CYC : 11) + 1);

  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
  localparam logic [HW-1:0] GAP_LAST  = HW'(2 * CLK_DIV - 1);
  localparam logic [BW-1:0] CMD_LAST  = BW'(10);
  localparam logic [BW-1:0] RD_LAST   = BW'(7);
  localparam logic [BW-1:0] TURN_LAST = BW'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);

  state_t        state, state_nxt;
  logic [HW-1:0] cnt, cnt_nxt;
  logic [BW-1:0] bit_cnt, bit_nxt;
  logic [9:0]    tx, tx_nxt;
  logic [7:0]    rx, rx_nxt;
  logic          is_rd, is_rd_nxt;
  logic          sck_nxt, ss_n_nxt, mosi_nxt;
  logic          rd_valid_q, rd_valid_nxt;
  logic [7:0]    rd_data_q, rd_data_nxt;

  assign host.cmd_ready = (state == IDLE) && !rst;
  assign host.rd_valid  = rd_valid_q;
  assign host.rd_data   = rd_data_q;
  assign host.state_dbg = state;

  always_ff @(posedge sclk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      tx         <= '0;
      rx         <= '0;
      is_rd      <= 1'b0;
      spi_sck    <= 1'b0;
      ss_n       <= 1'b1;
      mosi       <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bit_cnt    <= bit_nxt;
      tx         <= tx_nxt;
      rx         <= rx_nxt;
      is_rd      <= is_rd_nxt;
      spi_sck    <= sck_nxt;
      ss_n       <= ss_n_nxt;
      mosi       <= mosi_nxt;
      rd_valid_q <= rd_valid_nxt;
      rd_data_q  <= rd_data_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    bit_nxt      = bit_cnt;
    tx_nxt       = tx;
    rx_nxt       = rx;
    is_rd_nxt    = is_rd;
    sck_nxt      = spi_sck;
    ss_n_nxt     = ss_n;
    mosi_nxt     = mosi;
    rd_valid_nxt = 1'b0;
    rd_data_nxt  = rd_data_q;

    unique case (state)
      IDLE: begin
        if (host.cmd_valid) begin
          // The leading frame bit is the read/write type, i.e. op[1] repeated ahead of the opcode.
          state_nxt = CMD;
          cnt_nxt   = '0;
          bit_nxt   = '0;
          tx_nxt    = {host.cmd_op, host.cmd_data};
          is_rd_nxt = &host.cmd_op;
          ss_n_nxt  = 1'b0;
          sck_nxt   = 1'b0;
          mosi_nxt  = host.cmd_op[1];
        end
      end

      CMD, TURN, RD: begin
        // MISO is taken in the first high cycle of each read period, while the slave holds it steady.
        if (state == RD && spi_sck && cnt == '0) rx_nxt = {rx[6:0], miso};

        if (cnt != HALF_LAST) begin
          cnt_nxt = cnt + 1'b1;
        end else begin
          cnt_nxt = '0;
          sck_nxt = ~spi_sck;
          if (spi_sck) begin
            bit_nxt  = bit_cnt + 1'b1;
            mosi_nxt = 1'b0;
            case (state)
              CMD: begin
                if (bit_cnt == CMD_LAST) begin
                  bit_nxt = '0;
                  if (!is_rd) begin
                    state_nxt = GAP;
                    ss_n_nxt  = 1'b1;
                  end else if (TURN_CYC == 0) begin
                    state_nxt = RD;
                  end else begin
                    state_nxt = TURN;
                  end
                end else begin
                  mosi_nxt = tx[9];
                  tx_nxt   = {tx[8:0], 1'b0};
                end
              end
              TURN: begin
                if (bit_cnt == TURN_LAST) begin
                  bit_nxt   = '0;
                  state_nxt = RD;
                end
              end
              RD: begin
                if (bit_cnt == RD_LAST) begin
                  bit_nxt      = '0;
                  state_nxt    = GAP;
                  ss_n_nxt     = 1'b1;
                  rd_valid_nxt = 1'b1;
                  rd_data_nxt  = rx_nxt;
                end
              end
              default: ;
            endcase
          end
        end
      end

      GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule
